// File: rtl/pipeline_controller.sv
// Pipeline hazard, branch-flush and data-memory stall control.
// One FSM times each memory access; stall_cnt tallies frozen fetch cycles.
module pipeline_controller #(
   parameter int MEM_WAIT = 4,
   parameter int FWD_EN   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  src1,
   input  logic [3:0]  src2,
   input  logic        two_src,
   input  logic [3:0]  exe_dest,
   input  logic        exe_wb_en,
   input  logic        exe_mem_r_en,
   input  logic [3:0]  mem_dest,
   input  logic        mem_wb_en,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic        branch_taken,
   output logic        hazard,
   output logic        freeze_if,
   output logic        flush,
   output logic        mem_stall,
   output logic        mem_ready,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_WAIT - 1);

   state_t     state;
   state_t     state_n;
   logic [3:0] cnt;
   logic [3:0] cnt_n;
   logic       req;
   logic       raw_hazard;
   logic       stall_int;
   logic       ready_int;

   assign req = mem_r_en | mem_w_en;

   always_comb begin
      raw_hazard = 1'b0;
      if (FWD_EN != 0) begin
         raw_hazard = exe_mem_r_en & exe_wb_en &
                      ((exe_dest == src1) |
                       (two_src & (exe_dest == src2)));
      end else begin
         raw_hazard = (exe_wb_en & (exe_dest == src1)) |
                      (mem_wb_en & (mem_dest == src1)) |
                      (two_src &
                       ((exe_wb_en & (exe_dest == src2)) |
                        (mem_wb_en & (mem_dest == src2))));
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      stall_int = 1'b0;
      ready_int = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req) begin
               stall_int = 1'b1;
               if (MEM_WAIT >= 2) begin
                  state_n = S_WAIT;
                  cnt_n   = CNT_INIT;
               end else begin
                  state_n = S_DONE;
               end
            end
         end
         S_WAIT: begin
            stall_int = 1'b1;
            cnt_n     = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_n = S_DONE;
            end
         end
         // The request still visible here belongs to the retiring access.
         S_DONE: begin
            ready_int = 1'b1;
            state_n   = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   assign mem_stall = ~rst & stall_int;
   assign mem_ready = ~rst & ready_int;
   assign flush     = ~rst & branch_taken & ~stall_int;
   assign hazard    = ~rst & raw_hazard & ~branch_taken & ~stall_int;
   // Branch wins over a data hazard so the PC can load the target.
   assign freeze_if = ~rst & (stall_int | (raw_hazard & ~branch_taken));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'd0;
      end else if (freeze_if && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller.
// Three instances cover FWD_EN=0/1 and MEM_WAIT=4/1.
module tb_pipeline_controller;

   logic        clk;
   logic        rst;
   logic [3:0]  src1, src2, exe_dest, mem_dest;
   logic        two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic        mem_r_en, mem_w_en, branch_taken;

   logic        hz0, fz0, fl0, ms0, mr0;
   logic [15:0] sc0;
   logic        hz1, fz1, fl1, ms1, mr1;
   logic [15:0] sc1;
   logic        hzw, fzw, flw, msw, mrw;
   logic [15:0] scw;

   int checks = 0;
   int errors = 0;

   pipeline_controller #(.MEM_WAIT(4), .FWD_EN(0)) dut (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
      .mem_w_en(mem_w_en), .branch_taken(branch_taken),
      .hazard(hz0), .freeze_if(fz0), .flush(fl0), .mem_stall(ms0),
      .mem_ready(mr0), .stall_cnt(sc0)
   );

   pipeline_controller #(.MEM_WAIT(4), .FWD_EN(1)) dut_fwd (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
      .mem_w_en(mem_w_en), .branch_taken(branch_taken),
      .hazard(hz1), .freeze_if(fz1), .flush(fl1), .mem_stall(ms1),
      .mem_ready(mr1), .stall_cnt(sc1)
   );

   pipeline_controller #(.MEM_WAIT(1), .FWD_EN(0)) dut_w1 (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
      .mem_w_en(mem_w_en), .branch_taken(branch_taken),
      .hazard(hzw), .freeze_if(fzw), .flush(flw), .mem_stall(msw),
      .mem_ready(mrw), .stall_cnt(scw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      src1 = 4'd0; src2 = 4'd0; two_src = 1'b0;
      exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
      mem_dest = 4'd0; mem_wb_en = 1'b0;
      mem_r_en = 1'b0; mem_w_en = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
      mem_r_en = 1'b1; branch_taken = 1'b1;
      #1;
      checks++;
      if ({hz0, fz0, fl0, ms0, mr0} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outs got %b exp 00000", {hz0, fz0, fl0, ms0, mr0});
      end
      @(posedge clk); #1;
      checks++;
      if (sc0 !== 16'd0 || {hz1, fz1, msw, mrw} !== 4'b0) begin
         errors++;
         $display("FAIL reset_cnt got %0d exp 0", sc0);
      end
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
   endtask

   task automatic test_raw_nofwd();
      do_reset();
      src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
      #1;
      checks++;
      if ({hz0, fz0, fl0} !== 3'b110) begin
         errors++;
         $display("FAIL raw_exe_src1 got %b exp 110", {hz0, fz0, fl0});
      end
      @(negedge clk);
      src1 = 4'd0; src2 = 4'd3; two_src = 1'b0;
      #1;
      checks++;
      if (hz0 !== 1'b0) begin
         errors++;
         $display("FAIL raw_src2_unused got %b exp 0", hz0);
      end
      @(negedge clk);
      two_src = 1'b1;
      #1;
      checks++;
      if (hz0 !== 1'b1) begin
         errors++;
         $display("FAIL raw_src2_used got %b exp 1", hz0);
      end
      @(negedge clk);
      clear_inputs();
      src1 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1'b1;
      #1;
      checks++;
      if ({hz0, hz1} !== 2'b10) begin
         errors++;
         $display("FAIL raw_mem_src1 got %b exp 10", {hz0, hz1});
      end
      @(negedge clk);
      mem_wb_en = 1'b0;
      #1;
      checks++;
      if (hz0 !== 1'b0) begin
         errors++;
         $display("FAIL raw_mem_nowb got %b exp 0", hz0);
      end
   endtask

   task automatic test_raw_fwd();
      do_reset();
      src1 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b0;
      #1;
      checks++;
      if ({hz1, fz1} !== 2'b00) begin
         errors++;
         $display("FAIL fwd_alu got %b exp 00", {hz1, fz1});
      end
      @(negedge clk);
      exe_mem_r_en = 1'b1;
      #1;
      checks++;
      if ({hz1, fz1} !== 2'b11) begin
         errors++;
         $display("FAIL fwd_load_use got %b exp 11", {hz1, fz1});
      end
      @(negedge clk);
      src1 = 4'd0; src2 = 4'd5; two_src = 1'b1;
      #1;
      checks++;
      if (hz1 !== 1'b1) begin
         errors++;
         $display("FAIL fwd_src2 got %b exp 1", hz1);
      end
      @(negedge clk);
      two_src = 1'b0;
      #1;
      checks++;
      if (hz1 !== 1'b0) begin
         errors++;
         $display("FAIL fwd_src2_unused got %b exp 0", hz1);
      end
   endtask

   task automatic test_branch();
      do_reset();
      src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; branch_taken = 1'b1;
      #1;
      checks++;
      if ({fl0, hz0, fz0} !== 3'b100) begin
         errors++;
         $display("FAIL branch_over_raw got %b exp 100", {fl0, hz0, fz0});
      end
      @(negedge clk);
      mem_r_en = 1'b1;
      #1;
      checks++;
      if ({fl0, hz0, fz0, ms0} !== 4'b0011) begin
         errors++;
         $display("FAIL branch_in_stall got %b exp 0011", {fl0, hz0, fz0, ms0});
      end
   endtask

   task automatic test_mem_wait4();
      logic [5:0] exp_st;
      logic [5:0] exp_rd;
      exp_st = 6'b101111;
      exp_rd = 6'b010000;
      do_reset();
      mem_r_en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++;
         if ({ms0, mr0} !== {exp_st[c], exp_rd[c]}) begin
            errors++;
            $display("FAIL wait4_cyc%0d got %b exp %b", c + 1, {ms0, mr0},
                     {exp_st[c], exp_rd[c]});
         end
         if (c == 4) begin
            checks++;
            if (sc0 !== 16'd4) begin
               errors++;
               $display("FAIL wait4_stall_cnt got %0d exp 4", sc0);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_withdraw();
      logic [6:0] exp_st;
      logic [6:0] exp_rd;
      exp_st = 7'b0001111;
      exp_rd = 7'b0010000;
      do_reset();
      mem_r_en = 1'b1; mem_w_en = 1'b1;
      for (int c = 0; c < 7; c++) begin
         #1;
         checks++;
         if ({ms0, mr0} !== {exp_st[c], exp_rd[c]}) begin
            errors++;
            $display("FAIL withdraw_cyc%0d got %b exp %b", c + 1, {ms0, mr0},
                     {exp_st[c], exp_rd[c]});
         end
         @(negedge clk);
         mem_r_en = 1'b0; mem_w_en = 1'b0;
      end
   endtask

   task automatic test_mem_wait1();
      logic [2:0] exp_st;
      logic [2:0] exp_rd;
      exp_st = 3'b001;
      exp_rd = 3'b010;
      do_reset();
      mem_w_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if ({msw, mrw} !== {exp_st[c], exp_rd[c]}) begin
            errors++;
            $display("FAIL wait1_cyc%0d got %b exp %b", c + 1, {msw, mrw},
                     {exp_st[c], exp_rd[c]});
         end
         @(negedge clk);
         mem_w_en = 1'b0;
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [4:0] exp_st;
      logic [4:0] exp_rd;
      exp_st = 5'b01111;
      exp_rd = 5'b10000;
      do_reset();
      mem_r_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({hz0, fz0, fl0, ms0, mr0} !== 5'b0 || sc0 !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid_wait got %b cnt %0d exp 00000 cnt 0",
                  {hz0, fz0, fl0, ms0, mr0}, sc0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if ({ms0, mr0} !== {exp_st[c], exp_rd[c]}) begin
            errors++;
            $display("FAIL rst_restart_cyc%0d got %b exp %b", c + 1,
                     {ms0, mr0}, {exp_st[c], exp_rd[c]});
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_raw_nofwd();
      test_raw_fwd();
      test_branch();
      test_mem_wait4();
      test_withdraw();
      test_mem_wait1();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
